ram_burst_master: RTL and testbench

- Initiator side of the 16x512 synchronous RAM port: it drives WE/addr/in and consumes out.
- Accepts burst commands (write or read, start address, length). Write bursts stream words into RAM; read bursts stream RAM words out with backpressure.
- Sits between the datapath/PC-side logic and the RAM so that no other block sequences RAM addresses directly.

---
 rtl/ram_burst_pkg.sv | 17 +
 rtl/ram_rd_fifo.sv | 52 +++++
 rtl/ram_burst_master.sv | 135 +++++++++++++
 tb/tb_ram_burst_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_pkg.sv
// Shared constants and types for the RAM burst master and its read-return FIFO.
package ram_burst_pkg;

    localparam int RAM_AW = 9;
    localparam int RAM_DW = 16;

    localparam logic WE_WRITE = 1'b0;
    localparam logic WE_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding RAM read returns until the consumer takes them.
module ram_rd_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_head,
    output logic [CW-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero when empty so rd_data is defined before the first push.
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ram_burst_master.sv
// Burst master for the 16x512 synchronous RAM port: sequences write and read
// bursts, buffering read returns so the consumer can apply backpressure.
module ram_burst_master #(
    parameter int AW         = ram_burst_pkg::RAM_AW,
    parameter int DW         = ram_burst_pkg::RAM_DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          ram_WE,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_in,
    input  logic [DW-1:0] ram_out
);
    import ram_burst_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_cur_addr;
    logic [AW-1:0] r_remaining;
    logic          r_rd_p0;
    logic          r_rd_p1;
    logic          r_done;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_wr_beat;
    logic          w_issue;
    logic          w_pop;
    logic          w_last_pop;

    // Occupancy counts words in the FIFO plus reads still travelling through the RAM.
    assign w_occ      = {1'b0, w_count} + (CW + 1)'(r_rd_p0) + (CW + 1)'(r_rd_p1);
    assign w_wr_beat  = wr_valid & wr_ready;
    assign w_issue    = (r_state == ST_READ) && (w_occ < (CW + 1)'(FIFO_DEPTH));
    assign w_pop      = rd_valid & rd_ready;
    assign w_last_pop = (r_state == ST_DRAIN) && w_pop && (w_count == CW'(1))
                        && !r_rd_p0 && !r_rd_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid) w_next = cmd_write ? ST_WRITE : ST_READ;
            ST_WRITE: if (r_done) w_next = ST_IDLE;
            ST_READ:  if (w_issue && (r_remaining == '0)) w_next = ST_DRAIN;
            ST_DRAIN: if (r_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The done cycle keeps the FSM out of IDLE, which blocks extra beats and commands.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_WRITE: wr_ready = !r_done;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_rd_p0     <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_done      <= 1'b0;
            ram_WE      <= WE_READ;
            ram_addr    <= '0;
            ram_in      <= '0;
        end else begin
            ram_WE  <= WE_READ;
            r_done  <= 1'b0;
            r_rd_p0 <= w_issue;
            r_rd_p1 <= r_rd_p0;
            if ((r_state == ST_IDLE) && cmd_valid) begin
                r_cur_addr  <= cmd_addr;
                r_remaining <= cmd_len;
            end
            if (w_wr_beat || w_issue) begin
                ram_addr    <= r_cur_addr;
                r_cur_addr  <= r_cur_addr + AW'(1);
                r_remaining <= r_remaining - AW'(1);
            end
            if (w_wr_beat) begin
                ram_WE <= WE_WRITE;
                ram_in <= wr_data;
            end
            if ((w_wr_beat && (r_remaining == '0)) || w_last_pop) r_done <= 1'b1;
        end
    end

    assign done = r_done;

    // Reads issued two edges earlier land in the FIFO with the RAM's registered output.
    ram_rd_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_p1),
        .i_data  (ram_out),
        .i_pop   (w_pop),
        .o_valid (rd_valid),
        .o_head  (rd_data),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master with a behavioural 16x512 synchronous RAM.
module tb_ram_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [8:0]  cmd_addr, cmd_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic        busy, done;
    logic        ram_WE;
    logic [8:0]  ram_addr;
    logic [15:0] ram_in, ram_out;

    logic [15:0] mem [512];
    logic [15:0] shadow [512];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc    = 0;
    int done_cnt = 0, done_cyc = -1;
    int rcv_cnt = 0, first_rv = -1, last_rx = -1;
    int we_cnt = 0, we_first = -1, we_last = -1;
    int max_occ = 0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;

    logic [24:0] exp_wr [$];
    logic [15:0] exp_rd [$];

    ram_burst_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .ram_WE    (ram_WE),
        .ram_addr  (ram_addr),
        .ram_in    (ram_in),
        .ram_out   (ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_WE == 1'b0) mem[ram_addr] <= ram_in;
        ram_out <= mem[ram_addr];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: scores RAM writes and read handshakes against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (ram_WE === 1'b0) begin
                if (exp_wr.size() == 0) check("wr_unexpected", {7'd0, ram_addr, ram_in}, 32'hffff_ffff);
                else check("wr_commit", {7'd0, ram_addr, ram_in}, {7'd0, exp_wr.pop_front()});
                we_cnt++;
                if (we_first < 0) we_first = cyc;
                we_last = cyc;
            end
            if (hold_v) check("rd_hold", {15'd0, rd_valid, rd_data}, {15'd0, 1'b1, hold_d});
            hold_v = rd_valid && !rd_ready;
            hold_d = rd_data;
            if (rd_valid && first_rv < 0) first_rv = cyc;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", {16'd0, rd_data}, 32'hffff_ffff);
                else check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
                rcv_cnt++;
                last_rx = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(dut.w_occ) > max_occ) max_occ = int'(dut.w_occ);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit w, input int a, input int l);
        int t;
        tick();
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = 9'(a);
        cmd_len   = 9'(l);
        t = 0;
        while (!cmd_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("cmd_accept_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input int a, input int n, input int base, input int step, input bit gap);
        int t;
        int sd;
        int ad;
        logic [15:0] d;
        sd = done_cnt;
        we_cnt = 0; we_first = -1; we_last = -1;
        send_cmd(1'b1, a, n - 1);
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                wr_valid = 1'b0;
                tick();
            end
            ad = (a + i) % 512;
            d  = 16'(base + i * step);
            shadow[ad] = d;
            exp_wr.push_back({9'(ad), d});
            wr_valid = 1'b1;
            wr_data  = d;
            t = 0;
            while (!wr_ready && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) check("wr_ready_timeout", 32'(t), 32'd0);
            tick();
        end
        wr_valid = 1'b0;
        t = 0;
        while (done_cnt == sd && t < 50) begin
            tick();
            t++;
        end
        repeat (2) tick();
        check("wr_done_once", 32'(done_cnt - sd), 32'd1);
        check("wr_beats", 32'(we_cnt), 32'(n));
        check("wr_span", 32'(we_last - we_first), gap ? 32'(2 * (n - 1)) : 32'(n - 1));
        check("wr_done_time", 32'(done_cyc), 32'(we_last));
    endtask

    task automatic read_burst(input int a, input int n, input bit bp);
        int t;
        int sr;
        int sd;
        for (int i = 0; i < n; i++) exp_rd.push_back(shadow[(a + i) % 512]);
        sr = rcv_cnt;
        sd = done_cnt;
        first_rv = -1;
        rd_ready = 1'b1;
        send_cmd(1'b0, a, n - 1);
        t = 0;
        while ((rcv_cnt - sr < n || done_cnt == sd) && t < 400) begin
            if (bp) rd_ready = ~rd_ready;
            tick();
            t++;
        end
        rd_ready = 1'b1;
        check("rd_count", 32'(rcv_cnt - sr), 32'(n));
        check("rd_latency", 32'(first_rv - acc), 32'd3);
        if (!bp) check("rd_throughput", 32'(last_rx - first_rv), 32'(n - 1));
        repeat (2) tick();
        check("rd_done_once", 32'(done_cnt - sd), 32'd1);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sd;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        repeat (2) tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_outputs", {21'd0, wr_ready, rd_valid, busy, done, ram_WE, 7'd0},
              {21'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0});
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_ram_port", {7'd0, ram_addr, ram_in}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        write_burst(0, 4, 10, 10, 1'b0);
        check("mem0", {16'd0, mem[0]}, 32'd10);
        check("mem3", {16'd0, mem[3]}, 32'd40);

        write_burst(4, 4, 50, 10, 1'b1);

        read_burst(0, 4, 1'b0);
        read_burst(0, 8, 1'b1);
        check("max_outstanding_le4", {31'd0, max_occ <= 4}, 32'd1);

        write_burst(510, 4, 1, 1, 1'b0);
        check("wrap_mem510", {16'd0, mem[510]}, 32'd1);
        check("wrap_mem511", {16'd0, mem[511]}, 32'd2);
        check("wrap_mem0",   {16'd0, mem[0]},   32'd3);
        check("wrap_mem1",   {16'd0, mem[1]},   32'd4);
        read_burst(510, 4, 1'b0);

        // Two-word read with the consumer stalled parks the FSM in DRAIN.
        rd_ready = 1'b0;
        send_cmd(1'b0, 4, 1);
        repeat (5) tick();
        check("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        sd = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {28'd0, rd_valid, ram_WE, busy, done}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        repeat (2) tick();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        repeat (3) tick();
        check("mid_rst_no_done", 32'(done_cnt - sd), 32'd0);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        read_burst(510, 1, 1'b0);

        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
